// File: rtl/mtr_pkg.sv
// Shared motor-control definitions: scheduler states and 12-bit speed limits.
package mtr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEL  = 2'd1,
    ST_CRUISE = 2'd2,
    ST_DECEL  = 2'd3
  } mtr_state_e;

  // Saturation bounds for the signed 12-bit speed commands, in 13-bit form.
  localparam logic signed [12:0] SAT12_MAX = 13'sd2047;
  localparam logic signed [12:0] SAT12_MIN = -13'sd2048;

endpackage

// File: rtl/spd_sat12.sv
// Clamps a 13-bit signed sum into the signed 12-bit speed-command range.
module spd_sat12
  import mtr_pkg::*;
(
  input  logic signed [12:0] sum_i,
  output logic signed [11:0] sat_o
);

  // Clamp to [-2048, 2047]; in-range values pass through unchanged.
  always_comb begin
    if (sum_i > SAT12_MAX) begin
      sat_o = SAT12_MAX[11:0];
    end else if (sum_i < SAT12_MIN) begin
      sat_o = SAT12_MIN[11:0];
    end else begin
      sat_o = sum_i[11:0];
    end
  end

endmodule

// File: rtl/spd_ramp_sched.sv
// Forward-speed ramp scheduler: accelerates/decelerates a forward speed on a
// prescaled tick and mixes in a steering correction to form left/right commands.
module spd_ramp_sched
  import mtr_pkg::*;
#(
  parameter int unsigned RAMP_DIV = 256,
  parameter int unsigned INC_SLOW = 4,
  parameter int unsigned INC_FAST = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic               stop_req,
  input  logic               estop,
  input  logic               fast_sel,
  input  logic [10:0]        tgt_spd,
  input  logic signed [11:0] steer,
  output logic signed [11:0] lft_spd,
  output logic signed [11:0] rght_spd,
  output logic               busy,
  output logic               mv_done
);

  localparam int unsigned     PW       = $clog2(RAMP_DIV);
  localparam logic [PW-1:0]   PRE_LAST = PW'(RAMP_DIV - 1);

  mtr_state_e         state_q, state_d;
  logic [10:0]        frwrd_q, frwrd_d;
  logic [PW-1:0]      pre_q, pre_d;
  logic signed [11:0] lft_q, lft_d;
  logic signed [11:0] rght_q, rght_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               tick;
  logic               go_ok;
  logic [10:0]        inc;
  logic [11:0]        dec;
  logic [11:0]        up_sum;
  logic [10:0]        up_val;
  logic [12:0]        dn_diff;
  logic [10:0]        dn_tgt_val;
  logic [10:0]        dn_zero_val;
  logic signed [12:0] l_sum, r_sum;
  logic signed [11:0] l_sat, r_sat;

  assign tick  = (pre_q == PRE_LAST);
  assign go_ok = (state_q == ST_IDLE) && go && !stop_req && !estop;
  assign inc   = fast_sel ? 11'(INC_FAST) : 11'(INC_SLOW);
  assign dec   = {inc, 1'b0};

  // Candidate ramp results: step up clamped at target, step down clamped at
  // target (cruise retarget) or at zero (deceleration).
  always_comb begin
    up_sum      = {1'b0, frwrd_q} + {1'b0, inc};
    up_val      = (up_sum >= {1'b0, tgt_spd}) ? tgt_spd : up_sum[10:0];
    dn_diff     = {2'b00, frwrd_q} - {1'b0, dec};
    dn_tgt_val  = (dn_diff[12] || (dn_diff[11:0] < {1'b0, tgt_spd})) ? tgt_spd : dn_diff[10:0];
    dn_zero_val = dn_diff[12] ? '0 : dn_diff[10:0];
  end

  // Prescaler wraps on tick and restarts on an accepted go so the first ramp
  // step lands a full period after the move begins.
  always_comb begin
    if (go_ok || tick) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  // Sequencing: estop dominates, then stop_req, then the per-tick ramp step.
  always_comb begin
    state_d = state_q;
    frwrd_d = frwrd_q;
    done_d  = 1'b0;
    if (estop) begin
      state_d = ST_IDLE;
      frwrd_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          frwrd_d = '0;
          if (go && !stop_req) state_d = ST_ACCEL;
        end
        ST_ACCEL: begin
          if (stop_req) begin
            state_d = ST_DECEL;
          end else if (tick) begin
            frwrd_d = up_val;
            if (up_val == tgt_spd) state_d = ST_CRUISE;
          end
        end
        ST_CRUISE: begin
          if (stop_req) begin
            state_d = ST_DECEL;
          end else if (tick) begin
            if (frwrd_q < tgt_spd) begin
              frwrd_d = up_val;
            end else if (frwrd_q > tgt_spd) begin
              frwrd_d = dn_tgt_val;
            end
          end
        end
        ST_DECEL: begin
          if (tick) begin
            frwrd_d = dn_zero_val;
            if (dn_zero_val == '0) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          frwrd_d = '0;
        end
      endcase
    end
  end

  assign l_sum = $signed({2'b00, frwrd_q}) + $signed({steer[11], steer});
  assign r_sum = $signed({2'b00, frwrd_q}) - $signed({steer[11], steer});

  spd_sat12 u_sat_lft (
    .sum_i (l_sum),
    .sat_o (l_sat)
  );

  spd_sat12 u_sat_rght (
    .sum_i (r_sum),
    .sat_o (r_sat)
  );

  // Output commands follow the current state; an idle drive is forced to zero.
  always_comb begin
    lft_d  = (state_q == ST_IDLE) ? '0 : l_sat;
    rght_d = (state_q == ST_IDLE) ? '0 : r_sat;
    busy_d = (state_d != ST_IDLE);
  end

  // State, ramp and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      frwrd_q <= '0;
      pre_q   <= '0;
      lft_q   <= '0;
      rght_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frwrd_q <= frwrd_d;
      pre_q   <= pre_d;
      lft_q   <= lft_d;
      rght_q  <= rght_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign lft_spd  = lft_q;
  assign rght_spd = rght_q;
  assign busy     = busy_q;
  assign mv_done  = done_q;

endmodule

// File: tb/tb_spd_ramp_sched.sv
// Bench for spd_ramp_sched: cycle-level reference model feeding a scoreboard,
// a segment table, random traffic and directed multi-cycle sequences.
module tb_spd_ramp_sched;

  localparam int unsigned RD    = 4;
  localparam int unsigned INC_S = 4;
  localparam int unsigned INC_F = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               go = 1'b0;
  logic               stop_req = 1'b0;
  logic               estop = 1'b0;
  logic               fast_sel = 1'b0;
  logic [10:0]        tgt_spd = '0;
  logic signed [11:0] steer = '0;
  logic signed [11:0] lft_spd;
  logic signed [11:0] rght_spd;
  logic               busy;
  logic               mv_done;

  always #5 clk = ~clk;

  spd_ramp_sched #(
    .RAMP_DIV (RD),
    .INC_SLOW (INC_S),
    .INC_FAST (INC_F)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go),
    .stop_req (stop_req),
    .estop    (estop),
    .fast_sel (fast_sel),
    .tgt_spd  (tgt_spd),
    .steer    (steer),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd),
    .busy     (busy),
    .mv_done  (mv_done)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: 0 idle, 1 accel, 2 cruise, 3 decel.
  int m_st, m_fr, m_pre;

  typedef struct {
    int l;
    int r;
    int b;
    int d;
  } exp_t;
  exp_t sb[$];

  function automatic int clamp12(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic void model_reset();
    m_st  = 0;
    m_fr  = 0;
    m_pre = 0;
    sb.delete();
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  function automatic void model_edge();
    exp_t e;
    int   ns, nf, tg, st, stp, dn;
    bit   tk, acc;
    tk  = (m_pre == int'(RD) - 1);
    stp = fast_sel ? int'(INC_F) : int'(INC_S);
    dn  = 2 * stp;
    tg  = int'(tgt_spd);
    st  = int'(steer);
    ns  = m_st;
    nf  = m_fr;
    e.d = 0;
    acc = (m_st == 0) && go && !stop_req && !estop;
    if (estop) begin
      ns = 0;
      nf = 0;
    end else if (m_st == 0) begin
      if (go && !stop_req) ns = 1;
    end else if (m_st == 1 || m_st == 2) begin
      if (stop_req) ns = 3;
      else if (tk) begin
        if (m_st == 1) begin
          nf = imin(m_fr + stp, tg);
          if (nf == tg) ns = 2;
        end else if (m_fr < tg) nf = imin(m_fr + stp, tg);
        else if (m_fr > tg) nf = imax(m_fr - dn, tg);
      end
    end else if (tk) begin
      nf = imax(m_fr - dn, 0);
      if (nf == 0) begin
        ns  = 0;
        e.d = 1;
      end
    end
    e.l   = (m_st == 0) ? 0 : clamp12(m_fr + st);
    e.r   = (m_st == 0) ? 0 : clamp12(m_fr - st);
    e.b   = (ns != 0) ? 1 : 0;
    m_pre = (acc || tk) ? 0 : m_pre + 1;
    m_st  = ns;
    m_fr  = nf;
    sb.push_back(e);
  endfunction

  // One clock: predict, let the DUT clock, then compare away from the edge.
  task automatic step();
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sb_lft", int'(lft_spd), e.l);
    check("sb_rght", int'(rght_spd), e.r);
    check("sb_busy", int'(busy), e.b);
    check("sb_done", int'(mv_done), e.d);
  endtask

  task automatic do_reset();
    go = 1'b0; stop_req = 1'b0; estop = 1'b0; fast_sel = 1'b0;
    tgt_spd = '0; steer = '0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_lft", int'(lft_spd), 0);
    check("rst_rght", int'(rght_spd), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(mv_done), 0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit go;
    bit stp;
    bit es;
    bit fs;
    int tgt;
    int str;
    int n;
    int exp_busy;
  } seg_t;

  initial begin
    seg_t seg[$];
    int   done_at, done_cnt, prev, nchg;
    int   dn_seq[4];

    seg.push_back('{1, 0, 0, 1,  300,    50, 100, 1});
    seg.push_back('{0, 0, 0, 0,  100,   -30, 120, 1});
    seg.push_back('{0, 1, 0, 0,  100,   -30,  80, 0});
    seg.push_back('{1, 0, 0, 0,    0, -2048,  12, 1});
    seg.push_back('{0, 1, 0, 0,    0, -2048,  10, 0});
    seg.push_back('{1, 1, 0, 0,   50,     0,   6, 0});
    seg.push_back('{0, 1, 0, 0,   50,     0,   4, 0});
    seg.push_back('{1, 0, 0, 1, 2047,  2047,  20, 1});
    seg.push_back('{1, 0, 1, 1, 2047,  2047,   5, 0});
    seg.push_back('{1, 0, 0, 1,  500,     0,  30, 1});
    seg.push_back('{0, 1, 0, 1,  500,   -77, 150, 0});

    do_reset();

    // Segment table: pulses on the first cycle, levels held for the segment.
    foreach (seg[i]) begin
      fast_sel = seg[i].fs;
      tgt_spd  = 11'(seg[i].tgt);
      steer    = 12'(seg[i].str);
      estop    = seg[i].es;
      for (int c = 0; c < seg[i].n; c++) begin
        go       = (c == 0) ? seg[i].go : 1'b0;
        stop_req = (c == 0) ? seg[i].stp : 1'b0;
        step();
      end
      go = 1'b0; stop_req = 1'b0; estop = 1'b0;
      check($sformatf("seg%0d_busy", i), int'(busy), seg[i].exp_busy);
    end

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      go       = ($urandom_range(15) == 0);
      stop_req = ($urandom_range(31) == 0);
      estop    = ($urandom_range(63) == 0);
      if (c % 50 == 0) fast_sel = $urandom_range(1) == 1;
      if (c % 40 == 0) tgt_spd = 11'($urandom_range(2047));
      if (c % 7 == 0) steer = 12'($urandom_range(4095));
      step();
    end
    go = 1'b0; stop_req = 1'b0; estop = 1'b0;

    // Slow ramp to 20 then graceful stop.
    do_reset();
    tgt_spd = 11'd20;
    go = 1'b1; step(); go = 1'b0;
    check("a_busy_after_go", int'(busy), 1);
    step();
    for (int k = 1; k <= 5; k++) begin
      repeat (4) step();
      check($sformatf("a_ramp%0d", k), int'(lft_spd), 4 * k);
    end
    stop_req = 1'b1; step(); stop_req = 1'b0;
    done_at = 0; done_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (mv_done) begin
        done_cnt++;
        if (done_at == 0) done_at = i;
      end
    end
    check("a_done_cycle", done_at, 10);
    check("a_done_count", done_cnt, 1);
    check("a_busy_end", int'(busy), 0);
    check("a_lft_end", int'(lft_spd), 0);
    check("a_rght_end", int'(rght_spd), 0);

    // Saturation at high speed with steering.
    do_reset();
    fast_sel = 1'b1; tgt_spd = 11'd2000; steer = 12'sd100;
    go = 1'b1; step(); go = 1'b0;
    repeat (520) step();
    check("s_lft_sat", int'(lft_spd), 2047);
    check("s_rght", int'(rght_spd), 1900);
    steer = -12'sd100; step();
    check("s_lft_neg", int'(lft_spd), 1900);
    check("s_rght_sat", int'(rght_spd), 2047);
    steer = 12'h800; step();
    check("s_lft_min_steer", int'(lft_spd), -48);
    check("s_rght_min_steer", int'(rght_spd), 2047);

    // Emergency stop during acceleration.
    do_reset();
    tgt_spd = 11'd20;
    go = 1'b1; step(); go = 1'b0;
    repeat (8) step();
    estop = 1'b1; step();
    check("e_busy", int'(busy), 0);
    check("e_done", int'(mv_done), 0);
    check("e_lft_last", int'(lft_spd), 8);
    go = 1'b1; step(); go = 1'b0;
    check("e_go_ignored", int'(busy), 0);
    check("e_lft_zero", int'(lft_spd), 0);
    step();
    estop = 1'b0;
    go = 1'b1; step(); go = 1'b0;
    check("e_restart_busy", int'(busy), 1);
    step();
    repeat (4) step();
    check("e_restart_from0", int'(lft_spd), 4);

    // Cruise retarget downward at slow rate.
    do_reset();
    fast_sel = 1'b1; tgt_spd = 11'd40;
    go = 1'b1; step(); go = 1'b0;
    repeat (20) step();
    check("c_cruise40", int'(lft_spd), 40);
    fast_sel = 1'b0; tgt_spd = 11'd10;
    dn_seq = '{32, 24, 16, 10};
    prev = 40; nchg = 0;
    repeat (24) begin
      step();
      if (int'(lft_spd) != prev) begin
        if (nchg < 4) check($sformatf("c_down%0d", nchg), int'(lft_spd), dn_seq[nchg]);
        nchg++;
        prev = int'(lft_spd);
      end
    end
    check("c_down_steps", nchg, 4);
    check("c_still_busy", int'(busy), 1);

    // go and stop_req together in idle.
    do_reset();
    tgt_spd = 11'd20;
    go = 1'b1; stop_req = 1'b1; step(); go = 1'b0; stop_req = 1'b0;
    check("g_busy_now", int'(busy), 0);
    repeat (4) step();
    check("g_busy_later", int'(busy), 0);

    // Asynchronous reset during deceleration.
    do_reset();
    tgt_spd = 11'd20;
    go = 1'b1; step(); go = 1'b0;
    repeat (24) step();
    stop_req = 1'b1; step(); stop_req = 1'b0;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("r_lft_async", int'(lft_spd), 0);
    check("r_rght_async", int'(rght_spd), 0);
    check("r_busy_async", int'(busy), 0);
    check("r_done_async", int'(mv_done), 0);
    model_reset();
    @(posedge clk);
    #1;
    check("r_done_held", int'(mv_done), 0);
    rst_n = 1'b1;
    go = 1'b1; step(); go = 1'b0;
    step();
    repeat (4) step();
    check("r_restart_from0", int'(lft_spd), 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
